// File: rtl/scpu_pkg.sv
// Shared definitions for the scpu instruction path: instruction width, the
// filler encoding, and the feeder control states.
package scpu_pkg;

  localparam int INSTR_W = 8;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 8'h00;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } feeder_state_t;

endpackage

// File: rtl/feeder_buf.sv
// Program store for instr_feeder: DEPTH x W register file with one synchronous
// write port and one combinational read port.
module feeder_buf #(
  parameter int DEPTH = 16,
  parameter int W     = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rd_data
);

  logic [W-1:0] mem [DEPTH];

  // NOTE: the array has no reset; count gates every read, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/instr_feeder.sv
// Loads a program over a valid/ready port and replays it, one word per
// unstalled cycle, into the scpu instruction input.
// Build option: define FEEDER_STEP_EN to add the single-step input `step`.
module instr_feeder
  import scpu_pkg::*;
#(
  parameter int                 DEPTH = 16,
  parameter logic [INSTR_W-1:0] NOP   = NOP_INSTR
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  input  logic [INSTR_W-1:0]     wr_data,
  input  logic                   start,
  input  logic                   clear,
  input  logic                   stall,
`ifdef FEEDER_STEP_EN
  input  logic                   step,
`endif
  output logic [INSTR_W-1:0]     instruction,
  output logic                   instr_valid,
  output logic                   busy,
  output logic                   done,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  feeder_state_t      state_q, state_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_d;
  logic [INSTR_W-1:0] instr_d;
  logic               valid_d;
  logic               wr_ready_d;
  logic               wr_en;
  logic [AW-1:0]      rd_addr;
  logic [INSTR_W-1:0] rd_data;
  logic               advance;
  logic               last_word;

`ifdef FEEDER_STEP_EN
  assign advance = ~stall & step;
`else
  assign advance = ~stall;
`endif

  // A launch from IDLE/DONE fetches word 0; in RUN the prefetch is the word after rd_ptr.
  assign rd_addr   = (state_q == RUN) ? rd_ptr_q + AW'(1) : '0;
  assign last_word = ({1'b0, rd_ptr_q} == count - CW'(1));

  feeder_buf #(
    .DEPTH (DEPTH),
    .W     (INSTR_W)
  ) u_buf (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (count[AW-1:0]),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  // NOTE: every output of this block is defaulted first so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    count_d  = count;
    rd_ptr_d = rd_ptr_q;
    instr_d  = instruction;
    valid_d  = instr_valid;
    wr_en    = 1'b0;

    if (clear) begin
      state_d  = IDLE;
      count_d  = '0;
      rd_ptr_d = '0;
      instr_d  = NOP;
      valid_d  = 1'b0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (wr_valid && wr_ready) begin
            wr_en   = 1'b1;
            count_d = count + CW'(1);
          end
          if (start) begin
            if (count != '0) begin
              state_d  = RUN;
              rd_ptr_d = '0;
              instr_d  = rd_data;
              valid_d  = 1'b1;
            end else begin
              state_d = DONE;
            end
          end
        end
        RUN: begin
          if (advance) begin
            if (last_word) begin
              state_d = DONE;
              instr_d = NOP;
              valid_d = 1'b0;
            end else begin
              rd_ptr_d = rd_ptr_q + AW'(1);
              instr_d  = rd_data;
            end
          end
        end
        default: begin
          state_d = IDLE;
          instr_d = NOP;
          valid_d = 1'b0;
        end
      endcase
    end

    // Registered so that wr_ready is low while reset is held.
    wr_ready_d = (state_d == IDLE) && (count_d < CW'(DEPTH));
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      count       <= '0;
      rd_ptr_q    <= '0;
      instruction <= NOP;
      instr_valid <= 1'b0;
      wr_ready    <= 1'b0;
    end else begin
      state_q     <= state_d;
      count       <= count_d;
      rd_ptr_q    <= rd_ptr_d;
      instruction <= instr_d;
      instr_valid <= valid_d;
      wr_ready    <= wr_ready_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);

endmodule

// File: doc/instr_feeder.md
Name: instr_feeder

Overview:
- Stimulus-side counterpart to the scpu commit monitor: drives the 8-bit instruction stream into the single-cycle CPU.
- Loads a program over a valid/ready write port into a local buffer.
- On start, replays the buffer one instruction per cycle into the CPU's instruction input and signals completion.
- Sits between the bench or host loader and the scpu instruction port.

Parameters:
- DEPTH, 16, program buffer entries; power of two, minimum 2.
- NOP, 8'h00, instruction driven whenever no valid program instruction is presented.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- wr_valid  in  1  load-side data valid.
- wr_ready  out  1  buffer accepts a load word this cycle.
- wr_data  in  8  program instruction to append.
- start  in  1  one-cycle pulse; begin replay.
- clear  in  1  one-cycle pulse; empty the buffer, return to IDLE.
- stall  in  1  CPU not consuming; hold the current instruction.
- instruction  out  8  instruction presented to the CPU.
- instr_valid  out  1  instruction is a program word, not filler.
- busy  out  1  replay in progress.
- done  out  1  sticky; the last program word was consumed.
- count  out  $clog2(DEPTH)+1  number of loaded words.

Behaviour:
- Reset (async, immediate) values:
  - instruction = NOP.
  - instr_valid, busy, done, wr_ready = 0.
  - count and all internal pointers = 0.
  - State = IDLE.
  - Buffer contents are don't-care.
- States and transitions:
  - IDLE:
    - wr_ready = (count < DEPTH).
    - A handshake (wr_valid & wr_ready) writes buf[count] and increments count.
    - start with count > 0 -> RUN, rd_ptr = 0, done cleared.
    - start with count == 0 -> DONE directly, done = 1 next cycle.
  - RUN:
    - wr_ready = 0; writes are ignored.
    - instruction/instr_valid are registered outputs: the cycle after entering RUN, instruction = buf[0] and instr_valid = 1.
    - Each cycle with stall = 0: rd_ptr advances and the next word is presented the following cycle.
    - stall = 1: instruction, instr_valid and rd_ptr hold.
    - When the word at rd_ptr == count-1 is presented with stall = 0: next cycle -> DONE, instruction = NOP, instr_valid = 0, done = 1.
  - DONE:
    - Outputs NOP; busy = 0; done stays 1.
    - wr_ready = 0 until clear; the buffer is preserved.
    - start -> RUN again (re-run of the same program).
- clear, in any state:
  - Next cycle: count = 0, state = IDLE, done = 0, outputs NOP.
  - clear has priority over start and over a simultaneous write.
- busy = 1 exactly while in RUN.
- Boundary conditions:
  - Full buffer (count == DEPTH): wr_ready = 0; wr_valid is held off without data loss.
  - start in RUN is ignored.
  - A single-word program gives instr_valid high for exactly 1 unstalled cycle.
- Throughput: one instruction per unstalled cycle; latency from start to the first valid instruction is 1 cycle.

Optional Feature:
- Macro: FEEDER_STEP_EN.
- Defined:
  - Adds input port step (1 bit).
  - In RUN, rd_ptr advances only on cycles with step = 1 and stall = 0.
  - The current instruction stays on the outputs between steps, which allows single-stepping the CPU under bench control.
- Not defined:
  - No step port.
  - Advancement is governed by stall alone, as above.

Decomposition:
- Shared package scpu_pkg:
  - Instruction width constant INSTR_W = 8.
  - NOP encoding.
  - Feeder state enum {IDLE, RUN, DONE}.
- Sub-module feeder_buf: DEPTH x 8 register file.
  - One synchronous write port.
  - One combinational read port.
  - Keeps the control FSM separate from storage.

Test Plan:
- Load 3 words (8'h11, 8'h22, 8'h33), then start.
  - Expected: instruction = 11, 22, 33 on consecutive cycles with instr_valid = 1.
  - Next cycle: NOP, instr_valid = 0, done = 1, busy = 0.
- Same program with stall = 1 asserted on the cycle 22 is presented, for 2 cycles.
  - Expected: 22 held for 3 cycles total, then 33; done arrives 2 cycles later than in the first test.
- Load DEPTH words with wr_valid held high for DEPTH+2 cycles.
  - Expected: wr_ready drops after DEPTH accepts; count = DEPTH; extra data not written.
- Assert rst mid-RUN after word 2.
  - Expected: immediately instruction = NOP, instr_valid = 0, busy = 0, count = 0.
  - A following start goes to DONE with done = 1.
- In DONE, pulse start again.
  - Expected: the identical sequence replays.
- Pulse clear and start in the same cycle.
  - Expected: IDLE, count = 0, no replay.
- With FEEDER_STEP_EN: pulse step every 4th cycle.
  - Expected: each word is held exactly 4 cycles.
